csc_expand: RTL and testbench
=============================

CSC_EXPAND -- requirements
Module: csc_expand

Interface
REQ-001 Parameter MAT_RANK, default 256, matrix dimension (OFDM_SYM_NUM*SUBCAR_NUM).
REQ-002 Parameter DATA_W, default 32, width of each real/imag value.
REQ-003 Parameter ROW_W, default $clog2(MAT_RANK), row/column index width.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 s_col_idx  input  ROW_W  column index of the incoming CSC column beat.
REQ-008 s_nnz  input  3  count of valid nonzero entries in the beat, 0..4.
REQ-009 s_row0..s_row3  input  ROW_W each  row index of nonzero entry 0..3.
REQ-010 s_val_r0..s_val_r3, s_val_i0..s_val_i3  input  DATA_W each  real/imag of entry 0..3.
REQ-011 s_vld  input  1 / s_rdy  output  1  column-beat handshake.
REQ-012 m_col_idx, m_row_idx  output  ROW_W  coordinates of the current dense element.
REQ-013 m_val_r, m_val_i  output  DATA_W  dense element value.
REQ-014 m_last  output  1  current element is row MAT_RANK-1 of the column.
REQ-015 m_mlast  output  1  m_last and m_col_idx==MAT_RANK-1.
REQ-016 m_vld  input-side m_rdy  input  1 / m_vld  output  1  dense-element handshake.
REQ-017 err  output  1  sticky format-error flag.

Function
REQ-018 Block SHALL expand each CSC column beat into MAT_RANK dense elements, rows 0..MAT_RANK-1 ascending, zero-filled except at listed rows.
REQ-019 States SHALL be IDLE and EXPAND; reset state IDLE.
REQ-020 IDLE: s_rdy=1, m_vld=0; on s_vld&&s_rdy latch all s_* fields, row counter r<=0, entry pointer k<=0, go EXPAND.
REQ-021 EXPAND: m_vld=1; m_row_idx=r; m_col_idx=latched column.
REQ-022 Element value SHALL be entry k when k<nnz and row[k]==r, else 0+0j.
REQ-023 On m_vld&&m_rdy: k increments if entry k matched; if r==MAT_RANK-1 the column ends, else r increments.
REQ-024 While m_vld=1 and m_rdy=0 all m_* outputs SHALL hold stable.
REQ-025 s_rdy SHALL also be 1 in EXPAND when r==MAT_RANK-1 and m_rdy=1 (combinational on m_rdy), allowing back-to-back columns with no bubble; accept there reloads r=0,k=0, stays EXPAND.
REQ-026 Column end without simultaneous accept SHALL return to IDLE.
REQ-027 Latency: first dense element valid the cycle after input accept; sustained throughput one element per cycle, MAT_RANK cycles per column.
REQ-028 m_* outputs other than via s_rdy SHALL depend only on registered state.
REQ-029 s_nnz>4 SHALL be clamped to 4 and set err.
REQ-030 Valid entries not strictly ascending in row (row[j]>=row[j+1], j+1<nnz) SHALL set err at accept; unreachable entries are dropped, expansion still emits exactly MAT_RANK elements.
REQ-031 s_nnz==0 SHALL produce an all-zero column.
REQ-032 err SHALL stay set until reset.

Reset
REQ-033 rst=1 SHALL force IDLE, m_vld=0, s_rdy=0 during reset cycle, r=0, k=0, err=0, m_last=0, m_mlast=0, m_val_r/i=0, m_row_idx/m_col_idx=0.
REQ-034 Reset mid-column SHALL abandon the column; s_rdy=1 the first cycle after rst deasserts.

Verification
REQ-035 MAT_RANK=8, col 3, nnz=2 rows {1,6} values {5+2j,-7+0j}, m_rdy=1 -> 8 beats, row1=5+2j, row6=-7, others 0, m_last on row7, m_mlast=0.
REQ-036 Col 7, nnz=4 rows {0,2,4,7}, m_rdy toggled 1/0 each cycle -> 8 beats over 15 cycles, outputs stable during stalls, m_mlast=1 on row7.
REQ-037 Two beats presented back-to-back, m_rdy=1 -> 16 consecutive m_vld cycles, second accept on first column's row7 cycle, no bubble.
REQ-038 nnz=5 rows {0,1,2,3} -> err=1, first four rows expanded; nnz=2 rows {5,3} -> err=1, row5 emitted, row3 dropped (zero).
REQ-039 rst asserted at row 4 of an expanding column -> next cycle m_vld=0, err=0, s_rdy=1; new column expands from row 0.

Source files
------------

// File: rtl/csc_expand.sv
// Expands one compressed-sparse-column beat (up to four nonzeros) into a dense
// column of MAT_RANK elements, streamed one element per cycle in ascending row order.
module csc_expand #(
  parameter int MAT_RANK = 256,
  parameter int DATA_W   = 32,
  parameter int ROW_W    = $clog2(MAT_RANK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  s_col_idx,
  input  logic [2:0]        s_nnz,
  input  logic [ROW_W-1:0]  s_row0,
  input  logic [ROW_W-1:0]  s_row1,
  input  logic [ROW_W-1:0]  s_row2,
  input  logic [ROW_W-1:0]  s_row3,
  input  logic [DATA_W-1:0] s_val_r0,
  input  logic [DATA_W-1:0] s_val_r1,
  input  logic [DATA_W-1:0] s_val_r2,
  input  logic [DATA_W-1:0] s_val_r3,
  input  logic [DATA_W-1:0] s_val_i0,
  input  logic [DATA_W-1:0] s_val_i1,
  input  logic [DATA_W-1:0] s_val_i2,
  input  logic [DATA_W-1:0] s_val_i3,
  input  logic              s_vld,
  output logic              s_rdy,
  output logic [ROW_W-1:0]  m_col_idx,
  output logic [ROW_W-1:0]  m_row_idx,
  output logic [DATA_W-1:0] m_val_r,
  output logic [DATA_W-1:0] m_val_i,
  output logic              m_last,
  output logic              m_mlast,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic              err
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t state, state_nxt;

  logic [ROW_W-1:0]  col_q;
  logic [ROW_W-1:0]  r;
  logic [2:0]        nnz_q;
  logic [2:0]        k;
  logic [ROW_W-1:0]  row_q [4];
  logic [DATA_W-1:0] vr_q  [4];
  logic [DATA_W-1:0] vi_q  [4];

  logic [ROW_W-1:0]  s_row [4];
  logic [2:0]        nnz_clamp;
  logic              fmt_err;
  logic              expanding;
  logic              last_row;
  logic              hit;
  logic              accept;

  assign s_row[0]  = s_row0;
  assign s_row[1]  = s_row1;
  assign s_row[2]  = s_row2;
  assign s_row[3]  = s_row3;
  assign expanding = (state == EXPAND);
  assign last_row  = (r == ROW_W'(MAT_RANK - 1));
  assign hit       = (k < nnz_q) && (row_q[k[1:0]] == r);
  assign accept    = s_vld && s_rdy;

  // Beat sanity: clamp oversize counts and flag non-ascending valid rows.
  always_comb begin
    nnz_clamp = (s_nnz > 3'd4) ? 3'd4 : s_nnz;
    fmt_err   = (s_nnz > 3'd4);
    for (int j = 0; j < 3; j++) begin
      if ((3'(j + 1) < nnz_clamp) && (s_row[j] >= s_row[j + 1])) fmt_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (m_rdy && last_row && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // s_rdy looks through to m_rdy on the final row so columns chain without a bubble.
  always_comb begin
    s_rdy     = !rst && (!expanding || (last_row && m_rdy));
    m_vld     = expanding;
    m_row_idx = expanding ? r : '0;
    m_col_idx = expanding ? col_q : '0;
    m_val_r   = (expanding && hit) ? vr_q[k[1:0]] : '0;
    m_val_i   = (expanding && hit) ? vi_q[k[1:0]] : '0;
    m_last    = expanding && last_row;
    m_mlast   = expanding && last_row && (col_q == ROW_W'(MAT_RANK - 1));
  end

  // An out-of-order entry stalls k forever, so it and every later entry are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      nnz_q <= '0;
      r     <= '0;
      k     <= '0;
      err   <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        row_q[j] <= '0;
        vr_q[j]  <= '0;
        vi_q[j]  <= '0;
      end
    end else if (accept) begin
      col_q    <= s_col_idx;
      nnz_q    <= nnz_clamp;
      r        <= '0;
      k        <= '0;
      err      <= err | fmt_err;
      row_q[0] <= s_row0;
      row_q[1] <= s_row1;
      row_q[2] <= s_row2;
      row_q[3] <= s_row3;
      vr_q[0]  <= s_val_r0;
      vr_q[1]  <= s_val_r1;
      vr_q[2]  <= s_val_r2;
      vr_q[3]  <= s_val_r3;
      vi_q[0]  <= s_val_i0;
      vi_q[1]  <= s_val_i1;
      vi_q[2]  <= s_val_i2;
      vi_q[3]  <= s_val_i3;
    end else if (expanding && m_rdy) begin
      if (hit) k <= k + 3'd1;
      r <= last_row ? '0 : r + ROW_W'(1);
    end
  end

endmodule

// File: tb/tb_csc_expand.sv
// Bench for csc_expand: directed and random column beats checked against a
// dense-column reference model and a cycle-level handshake model.
module tb_csc_expand;

  localparam int MAT_RANK = 8;
  localparam int DATA_W   = 32;
  localparam int ROW_W    = 3;

  typedef struct {
    logic [ROW_W-1:0]            col;
    logic [2:0]                  nnz;
    logic [3:0][ROW_W-1:0]       rows;
    logic [3:0][DATA_W-1:0]      vr;
    logic [3:0][DATA_W-1:0]      vi;
  } beat_t;

  typedef struct {
    logic [ROW_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] vr;
    logic [DATA_W-1:0] vi;
    logic              last;
    logic              mlast;
  } elem_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ROW_W-1:0]  s_col_idx;
  logic [2:0]        s_nnz;
  logic [ROW_W-1:0]  s_row0, s_row1, s_row2, s_row3;
  logic [DATA_W-1:0] s_val_r0, s_val_r1, s_val_r2, s_val_r3;
  logic [DATA_W-1:0] s_val_i0, s_val_i1, s_val_i2, s_val_i3;
  logic              s_vld;
  logic              s_rdy;
  logic [ROW_W-1:0]  m_col_idx, m_row_idx;
  logic [DATA_W-1:0] m_val_r, m_val_i;
  logic              m_last, m_mlast, m_vld, m_rdy, err;

  int     tests = 0;
  int     fails = 0;
  beat_t  send_q[$];
  elem_t  exp_q[$];
  logic   err_exp;
  int     rdy_mode;
  logic   rdy_phase;
  int     vld_cycles;
  logic   stall_prev;
  logic [DATA_W-1:0] snap_vr;
  logic [DATA_W-1:0] snap_vi;
  logic [15:0]       snap_misc;

  csc_expand #(.MAT_RANK(MAT_RANK), .DATA_W(DATA_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst),
    .s_col_idx(s_col_idx), .s_nnz(s_nnz),
    .s_row0(s_row0), .s_row1(s_row1), .s_row2(s_row2), .s_row3(s_row3),
    .s_val_r0(s_val_r0), .s_val_r1(s_val_r1), .s_val_r2(s_val_r2), .s_val_r3(s_val_r3),
    .s_val_i0(s_val_i0), .s_val_i1(s_val_i1), .s_val_i2(s_val_i2), .s_val_i3(s_val_i3),
    .s_vld(s_vld), .s_rdy(s_rdy),
    .m_col_idx(m_col_idx), .m_row_idx(m_row_idx),
    .m_val_r(m_val_r), .m_val_i(m_val_i),
    .m_last(m_last), .m_mlast(m_mlast), .m_vld(m_vld), .m_rdy(m_rdy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: the longest strictly ascending prefix of the clamped entries is placed
  // into an otherwise zero dense column; anything else marks a format error.
  task automatic modelExpand(input beat_t b);
    int                nnzc;
    int                p;
    logic              e;
    logic [DATA_W-1:0] dr [MAT_RANK];
    logic [DATA_W-1:0] di [MAT_RANK];
    elem_t             el;
    nnzc = (b.nnz > 4) ? 4 : int'(b.nnz);
    e    = (b.nnz > 4);
    p    = 0;
    for (int j = 0; j < nnzc; j++) begin
      if (j == p && (j == 0 || b.rows[j] > b.rows[j-1])) p++;
    end
    if (p < nnzc) e = 1'b1;
    for (int i = 0; i < MAT_RANK; i++) begin
      dr[i] = '0;
      di[i] = '0;
    end
    for (int j = 0; j < p; j++) begin
      dr[b.rows[j]] = b.vr[j];
      di[b.rows[j]] = b.vi[j];
    end
    for (int i = 0; i < MAT_RANK; i++) begin
      el.col   = b.col;
      el.row   = ROW_W'(i);
      el.vr    = dr[i];
      el.vi    = di[i];
      el.last  = (i == MAT_RANK - 1);
      el.mlast = (i == MAT_RANK - 1) && (b.col == ROW_W'(MAT_RANK - 1));
      exp_q.push_back(el);
    end
    err_exp = err_exp | e;
  endtask

  function automatic beat_t mkBeat(input logic [ROW_W-1:0] col, input logic [2:0] nnz,
                                   input logic [3:0][ROW_W-1:0] rows);
    beat_t b;
    b.col  = col;
    b.nnz  = nnz;
    b.rows = rows;
    for (int j = 0; j < 4; j++) begin
      b.vr[j] = $urandom;
      b.vi[j] = $urandom;
    end
    return b;
  endfunction

  // One clock cycle: drive at the falling edge, check settled outputs, advance the model.
  task automatic applyStimulus();
    logic exp_s_rdy;
    logic s_acc;
    @(negedge clk);
    if (send_q.size() > 0) begin
      s_vld     = 1'b1;
      s_col_idx = send_q[0].col;
      s_nnz     = send_q[0].nnz;
      s_row0    = send_q[0].rows[0];
      s_row1    = send_q[0].rows[1];
      s_row2    = send_q[0].rows[2];
      s_row3    = send_q[0].rows[3];
      s_val_r0  = send_q[0].vr[0];
      s_val_r1  = send_q[0].vr[1];
      s_val_r2  = send_q[0].vr[2];
      s_val_r3  = send_q[0].vr[3];
      s_val_i0  = send_q[0].vi[0];
      s_val_i1  = send_q[0].vi[1];
      s_val_i2  = send_q[0].vi[2];
      s_val_i3  = send_q[0].vi[3];
    end else begin
      s_vld = 1'b0;
    end
    case (rdy_mode)
      0:       m_rdy = 1'b1;
      1:       begin m_rdy = rdy_phase; rdy_phase = !rdy_phase; end
      default: m_rdy = 1'($urandom_range(0, 1));
    endcase
    #1;
    exp_s_rdy = (exp_q.size() == 0) || (exp_q[0].last && m_rdy);
    checkOutput("m_vld", 64'(m_vld), 64'(exp_q.size() > 0));
    checkOutput("s_rdy", 64'(s_rdy), 64'(exp_s_rdy));
    checkOutput("err", 64'(err), 64'(err_exp));
    if (m_vld && exp_q.size() > 0) begin
      vld_cycles++;
      checkOutput("m_col_idx", 64'(m_col_idx), 64'(exp_q[0].col));
      checkOutput("m_row_idx", 64'(m_row_idx), 64'(exp_q[0].row));
      checkOutput("m_val_r", 64'(m_val_r), 64'(exp_q[0].vr));
      checkOutput("m_val_i", 64'(m_val_i), 64'(exp_q[0].vi));
      checkOutput("m_last", 64'(m_last), 64'(exp_q[0].last));
      checkOutput("m_mlast", 64'(m_mlast), 64'(exp_q[0].mlast));
    end
    if (stall_prev && m_vld) begin
      checkOutput("stall_val_r", 64'(m_val_r), 64'(snap_vr));
      checkOutput("stall_val_i", 64'(m_val_i), 64'(snap_vi));
      checkOutput("stall_misc", 64'({8'h0, m_col_idx, m_row_idx, m_last, m_mlast}), 64'(snap_misc));
    end
    stall_prev = m_vld && !m_rdy;
    snap_vr    = m_val_r;
    snap_vi    = m_val_i;
    snap_misc  = {8'h0, m_col_idx, m_row_idx, m_last, m_mlast};
    s_acc = s_vld && exp_s_rdy;
    if (m_vld && m_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (s_acc) begin
      modelExpand(send_q[0]);
      void'(send_q.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_timeout", 64'(n < budget), 64'd1);
    applyStimulus();
  endtask

  task automatic doReset(input logic full_check);
    @(negedge clk);
    rst   = 1'b1;
    s_vld = 1'b0;
    #1;
    checkOutput("rst_s_rdy", 64'(s_rdy), 64'd0);
    @(negedge clk);
    #1;
    if (full_check) begin
      checkOutput("rst_m_vld", 64'(m_vld), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_m_last", 64'(m_last), 64'd0);
      checkOutput("rst_m_mlast", 64'(m_mlast), 64'd0);
      checkOutput("rst_m_val", 64'({m_val_r, m_val_i}), 64'd0);
      checkOutput("rst_m_idx", 64'({m_row_idx, m_col_idx}), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_s_rdy", 64'(s_rdy), 64'd1);
    checkOutput("post_rst_m_vld", 64'(m_vld), 64'd0);
    checkOutput("post_rst_err", 64'(err), 64'd0);
    send_q.delete();
    exp_q.delete();
    err_exp    = 1'b0;
    stall_prev = 1'b0;
  endtask

  initial begin
    beat_t b;
    int    n;
    logic [ROW_W-1:0] t;
    rst = 1'b1; s_vld = 1'b0; m_rdy = 1'b1; s_col_idx = '0; s_nnz = '0;
    s_row0 = '0; s_row1 = '0; s_row2 = '0; s_row3 = '0;
    s_val_r0 = '0; s_val_r1 = '0; s_val_r2 = '0; s_val_r3 = '0;
    s_val_i0 = '0; s_val_i1 = '0; s_val_i2 = '0; s_val_i3 = '0;
    err_exp = 1'b0; rdy_mode = 0; rdy_phase = 1'b0; vld_cycles = 0; stall_prev = 1'b0;
    snap_vr = '0; snap_vi = '0; snap_misc = '0;

    doReset(1'b1);

    // Column 3 with 5+2j at row 1 and -7 at row 6.
    b = mkBeat(3'd3, 3'd2, {3'd0, 3'd0, 3'd6, 3'd1});
    b.vr[0] = 32'd5; b.vi[0] = 32'd2; b.vr[1] = 32'hFFFF_FFF9; b.vi[1] = 32'd0;
    send_q.push_back(b);
    vld_cycles = 0;
    drain(40);
    checkOutput("col3_beats", 64'(vld_cycles), 64'd8);

    // Column 7 with m_rdy alternating; stalls must hold outputs stable.
    rdy_mode = 1; rdy_phase = 1'b0;
    send_q.push_back(mkBeat(3'd7, 3'd4, {3'd7, 3'd4, 3'd2, 3'd0}));
    vld_cycles = 0;
    drain(40);
    checkOutput("col7_stall_span", 64'(vld_cycles), 64'd15);

    // Back-to-back columns must stream without a gap.
    rdy_mode = 0;
    send_q.push_back(mkBeat(3'd1, 3'd3, {3'd0, 3'd5, 3'd3, 3'd0}));
    send_q.push_back(mkBeat(3'd2, 3'd1, {3'd0, 3'd0, 3'd0, 3'd7}));
    vld_cycles = 0;
    drain(60);
    checkOutput("b2b_vld_cycles", 64'(vld_cycles), 64'd16);

    // Oversize count, then an out-of-order pair after clearing the sticky flag.
    send_q.push_back(mkBeat(3'd4, 3'd5, {3'd3, 3'd2, 3'd1, 3'd0}));
    drain(40);
    checkOutput("err_nnz5", 64'(err), 64'd1);
    doReset(1'b0);
    send_q.push_back(mkBeat(3'd5, 3'd2, {3'd0, 3'd0, 3'd3, 3'd5}));
    drain(40);
    checkOutput("err_order", 64'(err), 64'd1);

    // Reset in the middle of a column, then a clean column from row 0.
    doReset(1'b0);
    send_q.push_back(mkBeat(3'd6, 3'd6, {3'd7, 3'd4, 3'd2, 3'd1}));
    n = 0;
    while (!(exp_q.size() > 0 && exp_q[0].row == 3'd4) && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("reach_row4", 64'(n < 50), 64'd1);
    doReset(1'b0);
    send_q.push_back(mkBeat(3'd0, 3'd1, {3'd0, 3'd0, 3'd0, 3'd0}));
    drain(40);

    // Randomized beats with random back-pressure.
    rdy_mode = 2;
    for (int c = 0; c < 40; c++) begin
      if (c % 10 == 0) doReset(1'b0);
      b = mkBeat(3'($urandom_range(0, 7)), 3'(($urandom_range(0, 9) == 0) ? $urandom_range(5, 7)
                                                                          : $urandom_range(0, 4)),
                 {3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)});
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3 - i; j++) begin
            if (b.rows[j] > b.rows[j+1]) begin
              t = b.rows[j]; b.rows[j] = b.rows[j+1]; b.rows[j+1] = t;
            end
          end
        end
      end
      send_q.push_back(b);
      if ($urandom_range(0, 1) == 1) drain(100);
    end
    drain(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
